// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Opcodes, FSM state encoding and instruction bit positions for cpu_core.
// Rev    : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_OUT   = 4'hA;
    localparam logic [3:0] OP_JC    = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int OP_MSB      = 15;
    localparam int OP_LSB      = 12;
    localparam int SRC_BIT     = 11;
    localparam int OUT_SEL_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_OPER   = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_HALT   = 4'd7,
        ST_TRAP   = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_core_if.sv
`default_nettype none
// ============================================================================
// Module : cpu_core_if
// Brief  : Start/busy RAM handshake between cpu_core (master) and the SPI RAM controller.
// Rev    : 1.0
// ============================================================================
interface cpu_core_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_start_read;
    logic                  mem_start_write;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_busy;

    modport master (
        output mem_addr, mem_wdata, mem_start_read, mem_start_write,
        input  mem_rdata, mem_busy
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_start_read, mem_start_write,
        output mem_rdata, mem_busy
    );
endinterface
`default_nettype wire

// File: rtl/cpu_decoder.sv
`default_nettype none
// ============================================================================
// Module : cpu_decoder
// Brief  : Combinational opcode decode; macro CPU_CARRY_EN makes opcode B (JC) legal.
// Rev    : 1.0
// ============================================================================
module cpu_decoder
    import cpu_pkg::*;
(
    input  wire  [3:0]  i_op,
    input  wire         i_src,
    output logic [15:0] o_op_hot,
    output logic        o_two_word,
    output logic        o_mem_read,
    output logic        o_unknown
);

    always_comb begin
        o_op_hot       = '0;
        o_op_hot[i_op] = 1'b1;
        o_two_word     = (i_op >= OP_LOAD) && (i_op <= OP_JZ);
        o_mem_read     = i_src && ((i_op == OP_LOAD) || ((i_op >= OP_ADD) && (i_op <= OP_XOR)));
`ifdef CPU_CARRY_EN
        o_two_word     = o_two_word || (i_op == OP_JC);
        o_unknown      = (i_op > OP_JC) && (i_op < OP_HALT);
`else
        o_unknown      = (i_op >= OP_JC) && (i_op < OP_HALT);
`endif
    end

endmodule
`default_nettype wire

// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
// Module : cpu_core
// Brief  : Multi-cycle accumulator CPU on a start/busy RAM port; CPU_CARRY_EN adds carry + JC.
// Rev    : 1.0
// ============================================================================
module cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int OUT_WIDTH  = 8
) (
    input  wire                  clk,
    input  wire                  rst_n,
    input  wire                  step,
    input  wire                  run,
    input  wire  [OUT_WIDTH-1:0] data_in,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 busy,
    output logic                 halt,
    output logic                 trap,
    cpu_core_if.master           mem
);

    localparam logic [ADDR_WIDTH-1:0] C_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] C_TWO = {{(ADDR_WIDTH-2){1'b0}}, 2'b10};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_opaddr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [DATA_WIDTH-1:0] r_accum;
    logic [DATA_WIDTH-1:0] r_value;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [OUT_WIDTH-1:0]  r_data_out;
    logic                  r_start_rd;
    logic                  r_start_wr;
    logic [1:0]            r_ign;
`ifdef CPU_CARRY_EN
    logic                  r_carry;
`endif

    logic [15:0]           w_hot;
    logic                  w_two_word;
    logic                  w_mem_rd;
    logic                  w_unknown;
    logic                  w_mem_done;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  w_unused_ok;

    cpu_decoder u_dec (
        .i_op       (r_inst[OP_MSB:OP_LSB]),
        .i_src      (r_inst[SRC_BIT]),
        .o_op_hot   (w_hot),
        .o_two_word (w_two_word),
        .o_mem_read (w_mem_rd),
        .o_unknown  (w_unknown)
    );

    // r_ign covers the start cycle and the cycle after it, where busy is not yet meaningful
    assign w_mem_done = (r_ign == 2'd0) && !mem.mem_busy;

    always_comb begin
        w_pc_next = r_pc + C_TWO;
        if (r_state == ST_DECODE)
            w_pc_next = r_pc + C_ONE;
        else if (w_hot[OP_JMP])
            w_pc_next = r_opaddr;
        else if (w_hot[OP_JZ] && (r_accum == '0))
            w_pc_next = r_opaddr;
`ifdef CPU_CARRY_EN
        else if (w_hot[OP_JC] && r_carry)
            w_pc_next = r_opaddr;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_opaddr    <= '0;
            r_mem_addr  <= '0;
            r_inst      <= '0;
            r_accum     <= '0;
            r_value     <= '0;
            r_mem_wdata <= '0;
            r_data_out  <= '0;
            r_start_rd  <= 1'b0;
            r_start_wr  <= 1'b0;
            r_ign       <= 2'd0;
`ifdef CPU_CARRY_EN
            r_carry     <= 1'b0;
`endif
        end else begin
            r_start_rd <= 1'b0;
            r_start_wr <= 1'b0;
            if (r_ign != 2'd0)
                r_ign <= r_ign - 2'd1;

            case (r_state)
                ST_IDLE: begin
                    if (step || run) begin
                        r_mem_addr <= r_pc;
                        r_start_rd <= 1'b1;
                        r_ign      <= 2'd2;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_mem_done) begin
                        r_inst  <= mem.mem_rdata;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_unknown) begin
                        r_state <= ST_TRAP;
                    end else if (w_hot[OP_HALT]) begin
                        r_state <= ST_HALT;
                    end else if (w_two_word) begin
                        r_mem_addr <= r_pc + C_ONE;
                        r_start_rd <= 1'b1;
                        r_ign      <= 2'd2;
                        r_state    <= ST_OPER;
                    end else begin
                        if (w_hot[OP_OUT])
                            r_data_out <= r_inst[OUT_SEL_BIT] ? r_accum[2*OUT_WIDTH-1:OUT_WIDTH]
                                                              : r_accum[OUT_WIDTH-1:0];
                        r_pc <= w_pc_next;
                        if (run) begin
                            r_mem_addr <= w_pc_next;
                            r_start_rd <= 1'b1;
                            r_ign      <= 2'd2;
                            r_state    <= ST_FETCH;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_OPER: begin
                    if (w_mem_done) begin
                        r_value  <= mem.mem_rdata;
                        r_opaddr <= mem.mem_rdata[ADDR_WIDTH-1:0];
                        if (w_mem_rd) begin
                            r_mem_addr <= mem.mem_rdata[ADDR_WIDTH-1:0];
                            r_start_rd <= 1'b1;
                            r_ign      <= 2'd2;
                            r_state    <= ST_MEMRD;
                        end else if (w_hot[OP_STORE]) begin
                            r_mem_addr  <= mem.mem_rdata[ADDR_WIDTH-1:0];
                            r_mem_wdata <= r_accum;
                            r_start_wr  <= 1'b1;
                            r_ign       <= 2'd2;
                            r_state     <= ST_MEMWR;
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_MEMRD: begin
                    if (w_mem_done) begin
                        r_value <= mem.mem_rdata;
                        r_state <= ST_EXEC;
                    end
                end
                ST_MEMWR: begin
                    if (w_mem_done)
                        r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_hot[OP_LOAD]) begin
                        r_accum <= r_value;
                    end else if (w_hot[OP_ADD]) begin
`ifdef CPU_CARRY_EN
                        {r_carry, r_accum} <= {1'b0, r_accum} + {1'b0, r_value};
`else
                        r_accum <= r_accum + r_value;
`endif
                    end else if (w_hot[OP_SUB]) begin
                        r_accum <= r_accum - r_value;
`ifdef CPU_CARRY_EN
                        r_carry <= (r_accum < r_value);
`endif
                    end else if (w_hot[OP_AND]) begin
                        r_accum <= r_accum & r_value;
                    end else if (w_hot[OP_OR]) begin
                        r_accum <= r_accum | r_value;
                    end else if (w_hot[OP_XOR]) begin
                        r_accum <= r_accum ^ r_value;
                    end
                    r_pc <= w_pc_next;
                    if (run) begin
                        r_mem_addr <= w_pc_next;
                        r_start_rd <= 1'b1;
                        r_ign      <= 2'd2;
                        r_state    <= ST_FETCH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_TRAP;
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE) && (r_state != ST_HALT) && (r_state != ST_TRAP);
    assign halt     = (r_state == ST_HALT);
    assign trap     = (r_state == ST_TRAP);
    assign data_out = r_data_out;

    assign mem.mem_addr        = r_mem_addr;
    assign mem.mem_wdata       = r_mem_wdata;
    assign mem.mem_start_read  = r_start_rd;
    assign mem.mem_start_write = r_start_wr;

    assign w_unused_ok = ^{data_in, r_inst, w_hot};

endmodule
`default_nettype wire
